sparse_chunk_pingpong: RTL and testbench

- Multi-bank successor to the single-buffer sparse data chunk store.
- Holds BANK_NUM independent chunks. Each chunk has a MEM_SIZE-bit sparsemap and MEM_SIZE nonzero bytes.
- The write side fills one bank while the PE read side consumes another. Banks rotate round-robin via a full/release handshake, so there is no stall between chunks.
- Sits between the feature/weight loader and the prefix-sum/PE datapath.

---
 rtl/sparse_chunk_pingpong.sv | 135 +++++++++++++
 tb/tb_sparse_chunk_pingpong.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_chunk_pingpong.sv
// Multi-bank sparse chunk store: the loader fills one bank while the PE side reads another.
// Optional per-bank nonzero counter enabled by defining SPARSE_CHUNK_NZ_COUNT_EN.
module sparse_chunk_pingpong #(
    parameter int MEM_SIZE        = 128,
    parameter int BUS_SIZE        = 16,
    parameter int PREFIX_SUM_SIZE = 16,
    parameter int BANK_NUM        = 2,
    localparam int BW    = (BANK_NUM > 1) ? $clog2(BANK_NUM) : 1,
    localparam int AW    = $clog2(MEM_SIZE) + 1,
    localparam int SW    = $clog2(MEM_SIZE / PREFIX_SUM_SIZE),
    localparam int BEATS = MEM_SIZE / BUS_SIZE,
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [BUS_SIZE-1:0]     wr_sparsemap_i,
    input  logic [BUS_SIZE*8-1:0]   wr_nonzero_data_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    output logic [BW-1:0]           wr_bank_o,
    input  logic                    flush_i,
    output logic                    rd_ready_o,
    output logic [BW-1:0]           rd_bank_o,
    input  logic                    rd_en_i,
    input  logic [AW-1:0]           rd_addr_i,
    output logic [7:0]              rd_data_o,
    output logic                    rd_data_valid_o,
    input  logic [SW-1:0]           rd_sparsemap_addr_i,
    output logic [PREFIX_SUM_SIZE-1:0] rd_sparsemap_o,
    input  logic                    rd_release_i,
    output logic [AW-1:0]           rd_nz_count_o
);

    logic [BANK_NUM-1:0]       full_r;
    logic [BW-1:0]             wr_bank_r;
    logic [BW-1:0]             rd_bank_r;
    logic [CW-1:0]             wr_count_r;
    logic [MEM_SIZE-1:0]       sparsemap_r [BANK_NUM];
    logic [MEM_SIZE-1:0][7:0]  data_r      [BANK_NUM];

    logic          wr_fire;
    logic          wr_last;
    logic          rel_fire;
    logic          rd_fire;
    logic          rd_in_range;
    logic [AW-2:0] rd_idx;

    function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
        return (b == BW'(BANK_NUM - 1)) ? '0 : b + BW'(1);
    endfunction

    // Ready flags depend only on registered state, so valid/release never loop back combinationally.
    assign wr_ready_o = !full_r[wr_bank_r];
    assign rd_ready_o = full_r[rd_bank_r];
    assign wr_bank_o  = wr_bank_r;
    assign rd_bank_o  = rd_bank_r;

    assign wr_fire     = wr_valid_i && wr_ready_o && !flush_i;
    assign wr_last     = (wr_count_r == CW'(BEATS - 1));
    assign rel_fire    = rd_release_i && rd_ready_o && !flush_i;
    assign rd_fire     = rd_en_i && rd_ready_o;
    assign rd_in_range = (rd_addr_i != '0) && (rd_addr_i <= AW'(MEM_SIZE));
    assign rd_idx      = rd_addr_i[AW-2:0] - (AW-1)'(1);

    assign rd_sparsemap_o = sparsemap_r[rd_bank_r][PREFIX_SUM_SIZE*rd_sparsemap_addr_i +: PREFIX_SUM_SIZE];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_r          <= '0;
            wr_bank_r       <= '0;
            rd_bank_r       <= '0;
            wr_count_r      <= '0;
            rd_data_o       <= 8'h00;
            rd_data_valid_o <= 1'b0;
        end else if (flush_i) begin
            full_r          <= '0;
            wr_bank_r       <= '0;
            rd_bank_r       <= '0;
            wr_count_r      <= '0;
            rd_data_valid_o <= 1'b0;
        end else begin
            // NOTE: non-blocking updates let release and last-beat set see the same pre-edge pointers.
            if (wr_fire) begin
                wr_count_r <= wr_last ? '0 : wr_count_r + CW'(1);
            end
            if (rel_fire) begin
                full_r[rd_bank_r] <= 1'b0;
                rd_bank_r         <= next_bank(rd_bank_r);
            end
            if (wr_fire && wr_last) begin
                full_r[wr_bank_r] <= 1'b1;
                wr_bank_r         <= next_bank(wr_bank_r);
            end
            rd_data_valid_o <= rd_fire;
            if (rd_fire) begin
                rd_data_o <= rd_in_range ? data_r[rd_bank_r][rd_idx] : 8'h00;
            end
        end
    end

    // NOTE: storage is cleared on reset because a zeroed chunk is part of the reset state; flush leaves it intact.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                sparsemap_r[b] <= '0;
                data_r[b]      <= '0;
            end
        end else if (wr_fire) begin
            sparsemap_r[wr_bank_r][BUS_SIZE*wr_count_r +: BUS_SIZE] <= wr_sparsemap_i;
            data_r[wr_bank_r][BUS_SIZE*wr_count_r +: BUS_SIZE]      <= wr_nonzero_data_i;
        end
    end

`ifdef SPARSE_CHUNK_NZ_COUNT_EN
    logic [AW-1:0] nz_count_r [BANK_NUM];
    logic [AW-1:0] beat_ones;

    assign beat_ones     = AW'($countones(wr_sparsemap_i));
    assign rd_nz_count_o = nz_count_r[rd_bank_r];

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            for (int b = 0; b < BANK_NUM; b++) begin
                nz_count_r[b] <= '0;
            end
        end else if (wr_fire) begin
            // The first beat of a chunk restarts the count instead of accumulating.
            nz_count_r[wr_bank_r] <= ((wr_count_r == '0) ? '0 : nz_count_r[wr_bank_r]) + beat_ones;
        end
    end
`else
    assign rd_nz_count_o = '0;
`endif

endmodule

// File: tb/tb_sparse_chunk_pingpong.sv
// Directed bench for sparse_chunk_pingpong: expected read bytes go into a scoreboard queue
// that a negedge monitor drains whenever the DUT flags rd_data_valid_o.
module tb_sparse_chunk_pingpong;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [15:0]  wr_sparsemap = '0;
    logic [127:0] wr_data = '0;
    logic         wr_valid = 1'b0;
    logic         flush = 1'b0;
    logic         rd_en = 1'b0;
    logic [7:0]   rd_addr = '0;
    logic [2:0]   rd_sm_addr = '0;
    logic         rd_release = 1'b0;
    logic         wr_ready, rd_ready, rd_data_valid;
    logic [0:0]   wr_bank, rd_bank;
    logic [7:0]   rd_data;
    logic [15:0]  rd_sparsemap;
    logic [7:0]   rd_nz_count;

    logic         wr_valid1 = 1'b0;
    logic         rd_en1 = 1'b0;
    logic         rd_release1 = 1'b0;
    logic [7:0]   rd_addr1 = '0;
    logic         wr_ready1, rd_ready1, rd_data_valid1;
    logic [0:0]   wr_bank1, rd_bank1;
    logic [7:0]   rd_data1;
    logic [15:0]  rd_sparsemap1;
    logic [7:0]   rd_nz_count1;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

`ifdef SPARSE_CHUNK_NZ_COUNT_EN
    localparam logic [7:0] NZ_FFFF  = 8'd128;
    localparam logic [7:0] NZ_A5A5  = 8'd64;
    localparam logic [7:0] NZ_MIXED = 8'd25;
`else
    localparam logic [7:0] NZ_FFFF  = 8'd0;
    localparam logic [7:0] NZ_A5A5  = 8'd0;
    localparam logic [7:0] NZ_MIXED = 8'd0;
`endif

    always #5 clk = ~clk;

    sparse_chunk_pingpong #(.MEM_SIZE(128), .BUS_SIZE(16), .PREFIX_SUM_SIZE(16), .BANK_NUM(2)) u_dut (
        .clk_i(clk), .rst_i(rst),
        .wr_sparsemap_i(wr_sparsemap), .wr_nonzero_data_i(wr_data), .wr_valid_i(wr_valid),
        .wr_ready_o(wr_ready), .wr_bank_o(wr_bank), .flush_i(flush),
        .rd_ready_o(rd_ready), .rd_bank_o(rd_bank), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid),
        .rd_sparsemap_addr_i(rd_sm_addr), .rd_sparsemap_o(rd_sparsemap),
        .rd_release_i(rd_release), .rd_nz_count_o(rd_nz_count)
    );

    sparse_chunk_pingpong #(.MEM_SIZE(128), .BUS_SIZE(16), .PREFIX_SUM_SIZE(16), .BANK_NUM(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst),
        .wr_sparsemap_i(wr_sparsemap), .wr_nonzero_data_i(wr_data), .wr_valid_i(wr_valid1),
        .wr_ready_o(wr_ready1), .wr_bank_o(wr_bank1), .flush_i(flush),
        .rd_ready_o(rd_ready1), .rd_bank_o(rd_bank1), .rd_en_i(rd_en1), .rd_addr_i(rd_addr1),
        .rd_data_o(rd_data1), .rd_data_valid_o(rd_data_valid1),
        .rd_sparsemap_addr_i(rd_sm_addr), .rd_sparsemap_o(rd_sparsemap1),
        .rd_release_i(rd_release1), .rd_nz_count_o(rd_nz_count1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        if (rd_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rd_unexpected_valid: got data %0h with no read outstanding", rd_data);
            end else begin
                check("rd_data", rd_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte j of beat k carries nonzero index 16k+j+1, offset by base.
    function automatic logic [127:0] beat_data(input int k, input int base);
        logic [127:0] v;
        for (int j = 0; j < 16; j++) v[8*j +: 8] = 8'(16*k + j + 1 + base);
        return v;
    endfunction

    function automatic logic [15:0] sm_of(input int mode, input int k);
        if (mode == 0) return 16'hFFFF;
        if (mode == 1) return 16'hA5A5;
        return (k == 3) ? 16'hA5A5 : 16'(16'h1000 + k);
    endfunction

    task automatic beat(input int sel, input int k, input int base, input int mode);
        wr_sparsemap = sm_of(mode, k);
        wr_data      = beat_data(k, base);
        if (sel == 0) wr_valid = 1'b1; else wr_valid1 = 1'b1;
        tick();
        wr_valid  = 1'b0;
        wr_valid1 = 1'b0;
    endtask

    task automatic fill(input int sel, input int base, input int k0, input int k1, input int mode);
        for (int k = k0; k <= k1; k++) beat(sel, k, base, mode);
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp);
        rd_en   = 1'b1;
        rd_addr = addr;
        exp_q.push_back(exp);
        tick();
        rd_en = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_wr_ready", wr_ready, 1);
        check("rst_rd_ready", rd_ready, 0);
        check("rst_rd_valid", rd_data_valid, 0);
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_wr_bank", wr_bank, 0);
        check("rst_rd_bank", rd_bank, 0);
        check("rst_nz", rd_nz_count, 0);

        // Bank 0: data equals its 1-based index, sparsemap all ones.
        fill(0, 0, 0, 7, 0);
        check("f0_rd_ready", rd_ready, 1);
        check("f0_wr_bank", wr_bank, 1);
        check("f0_wr_ready", wr_ready, 1);
        check("f0_rd_bank", rd_bank, 0);
        check("f0_nz", rd_nz_count, NZ_FFFF);
        rd(8'd1, 8'h01);
        rd(8'd128, 8'h80);
        rd(8'd0, 8'h00);
        rd(8'd200, 8'h00);
        rd(8'd17, 8'h11);

        // Bank 1 filled with no release: write side must stall.
        fill(0, 8'h40, 0, 7, 1);
        check("f1_wr_ready", wr_ready, 0);
        check("f1_wr_bank", wr_bank, 0);
        check("f1_rd_bank", rd_bank, 0);
        wr_sparsemap = 16'h0000;
        wr_data      = {16{8'hEE}};
        wr_valid     = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("blocked_wr_ready", wr_ready, 0);
        rd(8'd1, 8'h01);
        rd(8'd16, 8'h10);
        rd_sm_addr = 3'd3;
        #1;
        check("sm_bank0_w3", rd_sparsemap, 16'hFFFF);

        // Release in the same cycle as a read: the read still targets bank 0.
        rd_en      = 1'b1;
        rd_addr    = 8'd5;
        rd_release = 1'b1;
        exp_q.push_back(8'h05);
        tick();
        rd_en      = 1'b0;
        rd_release = 1'b0;
        check("rel_rd_bank", rd_bank, 1);
        check("rel_wr_ready", wr_ready, 1);
        check("rel_rd_ready", rd_ready, 1);
        check("rel_wr_bank", wr_bank, 0);
        check("sm_bank1_w3", rd_sparsemap, 16'hA5A5);
        check("f1_nz", rd_nz_count, NZ_A5A5);
        rd(8'd1, 8'h41);
        rd(8'd128, 8'hC0);

        // Refill bank 0, free bank 1, then finish bank 1 while releasing bank 0.
        fill(0, 8'h80, 0, 7, 0);
        check("f2_wr_ready", wr_ready, 0);
        check("f2_wr_bank", wr_bank, 1);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check("rel2_rd_bank", rd_bank, 0);
        check("rel2_wr_ready", wr_ready, 1);
        check("rel2_rd_ready", rd_ready, 1);
        fill(0, 8'h10, 0, 6, 2);
        rd_release = 1'b1;
        beat(0, 7, 8'h10, 2);
        rd_release = 1'b0;
        check("sim_rd_bank", rd_bank, 1);
        check("sim_wr_bank", wr_bank, 0);
        check("sim_rd_ready", rd_ready, 1);
        check("sim_wr_ready", wr_ready, 1);
        check("sim_sm_w3", rd_sparsemap, 16'hA5A5);
        rd_sm_addr = 3'd0;
        #1;
        check("sim_sm_w0", rd_sparsemap, 16'h1000);
        rd_sm_addr = 3'd7;
        #1;
        check("sim_sm_w7", rd_sparsemap, 16'h1007);
        check("sim_nz", rd_nz_count, NZ_MIXED);
        rd(8'd3, 8'h13);
        rd(8'd128, 8'h90);

        // Empty read bank: reads and releases are ignored.
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check("empty_rd_bank", rd_bank, 0);
        check("empty_rd_ready", rd_ready, 0);
        rd_en   = 1'b1;
        rd_addr = 8'd1;
        tick();
        rd_en = 1'b0;
        check("noready_valid", rd_data_valid, 0);
        check("noready_hold", rd_data, 8'h90);
        rd_release = 1'b1;
        tick();
        rd_release = 1'b0;
        check("noready_rel_bank", rd_bank, 0);

        // Flush after three beats, with a beat presented alongside the flush.
        fill(0, 8'h60, 0, 2, 0);
        flush        = 1'b1;
        wr_valid     = 1'b1;
        wr_sparsemap = 16'hFFFF;
        wr_data      = beat_data(3, 8'h60);
        tick();
        flush    = 1'b0;
        wr_valid = 1'b0;
        check("flush_rd_ready", rd_ready, 0);
        check("flush_wr_bank", wr_bank, 0);
        check("flush_wr_ready", wr_ready, 1);
        check("flush_rd_bank", rd_bank, 0);
        fill(0, 8'h20, 0, 4, 0);
        check("refill5_rd_ready", rd_ready, 0);
        fill(0, 8'h20, 5, 7, 0);
        check("refill_rd_ready", rd_ready, 1);
        check("refill_wr_bank", wr_bank, 1);
        check("refill_nz", rd_nz_count, NZ_FFFF);
        rd(8'd2, 8'h22);
        rd(8'd50, 8'h52);
        rd_en   = 1'b1;
        rd_addr = 8'd1;
        flush   = 1'b1;
        tick();
        rd_en = 1'b0;
        flush = 1'b0;
        check("flush_rd_valid", rd_data_valid, 0);
        check("flush2_rd_ready", rd_ready, 0);
        check("flush2_wr_bank", wr_bank, 0);

        // Single-bank build: fill, read, release, refill all on bank 0.
        fill(1, 8'h30, 0, 7, 0);
        check("b1_rd_ready", rd_ready1, 1);
        check("b1_wr_ready", wr_ready1, 0);
        check("b1_wr_bank", wr_bank1, 0);
        check("b1_rd_bank", rd_bank1, 0);
        rd_en1   = 1'b1;
        rd_addr1 = 8'd4;
        tick();
        rd_en1 = 1'b0;
        check("b1_rd_valid", rd_data_valid1, 1);
        check("b1_rd_data", rd_data1, 8'h34);
        rd_release1 = 1'b1;
        tick();
        rd_release1 = 1'b0;
        check("b1_rel_rd_ready", rd_ready1, 0);
        check("b1_rel_wr_ready", wr_ready1, 1);
        check("b1_rel_rd_bank", rd_bank1, 0);
        fill(1, 8'h50, 0, 7, 0);
        check("b1_refill_rd_ready", rd_ready1, 1);
        rd_en1 = 1'b1;
        tick();
        rd_en1 = 1'b0;
        check("b1_refill_data", rd_data1, 8'h54);

        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
